// File: rtl/shift_sequencer.sv
// shift_sequencer: serializes a parallel word onto ser_out/ser_en while
// capturing ser_in into a receive word. Both sides use valid/ready handshakes.
module shift_sequencer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_out,
    output logic             ser_en,
    input  logic             ser_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             done
);

    // Counter reaches WIDTH without wrapping.
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   tx;
    logic [WIDTH-1:0]   rx;
    logic [WIDTH-1:0]   tx_shifted;
    logic [WIDTH-1:0]   rx_shifted;
    logic [WIDTH-1:0]   out_data_q;
    logic [CNT_W-1:0]   cnt;
    logic               done_q;
    logic               last_shift;

    assign last_shift = (cnt == CNT_W'(WIDTH - 1));

    // Shift tx toward the output end; rx fills from the opposite end so the
    // first bit sent lands in the same bit position it came from.
    always_comb begin
        // NOTE: every signal written here gets a value on every path, otherwise a latch is inferred.
        tx_shifted = tx;
        rx_shifted = rx;
        if (MSB_FIRST) begin
            tx_shifted = {tx[WIDTH-2:0], 1'b0};
            rx_shifted = {rx[WIDTH-2:0], ser_in};
        end else begin
            tx_shifted = {1'b0, tx[WIDTH-1:1]};
            rx_shifted = {ser_in, rx[WIDTH-1:1]};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state <= state_next;
        end
    end

    // Next-state logic: accept in IDLE, WIDTH shift edges, hold DONE until consumed.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)   state_next = SHIFT;
            SHIFT:   if (last_shift) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Datapath: load on accept, shift/capture/count in SHIFT, latch result on the last shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: all datapath registers are reset so out_data and ser_out are defined straight out of reset.
            tx         <= '0;
            rx         <= '0;
            cnt        <= '0;
            out_data_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        tx  <= in_data;
                        rx  <= '0;
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    tx  <= tx_shifted;
                    rx  <= rx_shifted;
                    cnt <= cnt + 1'b1;
                    if (last_shift) begin
                        out_data_q <= rx_shifted;
                        done_q     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded purely from registers.
    assign in_ready  = (state == IDLE);
    assign ser_en    = (state == SHIFT);
    assign ser_out   = ser_en & (MSB_FIRST ? tx[WIDTH-1] : tx[0]);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Testbench for shift_sequencer: an MSB-first instance (mostly looped back)
// and an LSB-first instance driven with an explicit serial return pattern.
module tb_shift_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    // MSB-first instance
    logic       in_valid_m = 1'b0, in_ready_m, ser_out_m, ser_en_m, ser_in_m;
    logic       out_valid_m, out_ready_m = 1'b0, busy_m, done_m;
    logic [7:0] in_data_m = '0, out_data_m;
    logic       loop_m = 1'b1, ser_drv_m = 1'b0;

    // LSB-first instance
    logic       in_valid_l = 1'b0, in_ready_l, ser_out_l, ser_en_l, ser_in_l = 1'b0;
    logic       out_valid_l, out_ready_l = 1'b0, busy_l, done_l;
    logic [7:0] in_data_l = '0, out_data_l;

    // Scoreboards: expected received words.
    logic [7:0] sb_m[$];
    logic [7:0] sb_l[$];

    assign ser_in_m = loop_m ? ser_out_m : ser_drv_m;

    shift_sequencer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_m), .in_ready(in_ready_m), .in_data(in_data_m),
        .ser_out(ser_out_m), .ser_en(ser_en_m), .ser_in(ser_in_m),
        .out_valid(out_valid_m), .out_ready(out_ready_m), .out_data(out_data_m),
        .busy(busy_m), .done(done_m)
    );

    shift_sequencer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_l), .in_ready(in_ready_l), .in_data(in_data_l),
        .ser_out(ser_out_l), .ser_en(ser_en_l), .ser_in(ser_in_l),
        .out_valid(out_valid_l), .out_ready(out_ready_l), .out_data(out_data_l),
        .busy(busy_l), .done(done_l)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Called on the first SHIFT negedge; samples 8 cycles, returns on the first DONE negedge.
    // First bit observed ends up in seq[7].
    task automatic collect_m(output logic [7:0] seq, output int en_cnt);
        seq = '0;
        en_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            seq = {seq[6:0], ser_out_m};
            en_cnt += int'(ser_en_m);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        in_valid_m = 1'b1; in_data_m = 8'h5A;
        in_valid_l = 1'b1; in_data_l = 8'h5A;
        @(posedge clk);
        #1;
        in_valid_m = 1'b0; in_valid_l = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready_m, ser_out_m, ser_en_m, out_valid_m, busy_m, done_m} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_status_m: got %b expected 100000",
                     {in_ready_m, ser_out_m, ser_en_m, out_valid_m, busy_m, done_m});
        end
        checks++;
        if (out_data_m !== 8'h00) begin
            failures++;
            $display("FAIL reset_out_data_m: got %h expected 00", out_data_m);
        end
        checks++;
        if ({in_ready_l, ser_out_l, ser_en_l, out_valid_l, busy_l, done_l} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_status_l: got %b expected 100000",
                     {in_ready_l, ser_out_l, ser_en_l, out_valid_l, busy_l, done_l});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_loopback_msb();
        logic [7:0] seq;
        logic [7:0] exp;
        int         en_cnt;
        loop_m = 1'b1; out_ready_m = 1'b1;
        in_valid_m = 1'b1; in_data_m = 8'hA5; sb_m.push_back(8'hA5);
        @(negedge clk);
        in_valid_m = 1'b0; in_data_m = 8'hFF;  // post-accept change must not matter
        collect_m(seq, en_cnt);
        checks++;
        if (seq !== 8'hA5) begin
            failures++;
            $display("FAIL loop_msb_ser_out_seq: got %b expected 10100101", seq);
        end
        checks++;
        if (en_cnt != 8) begin
            failures++;
            $display("FAIL loop_msb_ser_en_cycles: got %0d expected 8", en_cnt);
        end
        // accept+9: first DONE cycle
        checks++;
        if ({done_m, out_valid_m, ser_en_m} !== 3'b110) begin
            failures++;
            $display("FAIL loop_msb_done_cycle: got done/valid/en %b expected 110",
                     {done_m, out_valid_m, ser_en_m});
        end
        exp = (sb_m.size() > 0) ? sb_m.pop_front() : 8'hxx;
        checks++;
        if (out_data_m !== exp) begin
            failures++;
            $display("FAIL loop_msb_out_data: got %h expected %h", out_data_m, exp);
        end
        @(negedge clk);
        checks++;
        if ({done_m, out_valid_m, in_ready_m} !== 3'b001) begin
            failures++;
            $display("FAIL loop_msb_back_to_idle: got done/valid/ready %b expected 001",
                     {done_m, out_valid_m, in_ready_m});
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] seq;
        logic [7:0] exp;
        int         en_cnt;
        int         done_cnt;
        int         hold_bad;
        loop_m = 1'b1; out_ready_m = 1'b0;
        in_valid_m = 1'b1; in_data_m = 8'h96; sb_m.push_back(8'h96);
        @(negedge clk);
        in_valid_m = 1'b0;
        collect_m(seq, en_cnt);
        // First DONE cycle: offer 8'h11 while the consumer stalls.
        in_valid_m = 1'b1; in_data_m = 8'h11;
        exp = (sb_m.size() > 0) ? sb_m.pop_front() : 8'hxx;
        done_cnt = 0;
        hold_bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid_m !== 1'b1 || out_data_m !== exp || in_ready_m !== 1'b0) hold_bad++;
            done_cnt += int'(done_m);
            if (i == 4) out_ready_m = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (hold_bad != 0) begin
            failures++;
            $display("FAIL bp_hold: %0d of 5 DONE cycles lost valid/data(%h)/ready-low, expected data %h",
                     hold_bad, out_data_m, exp);
        end
        done_cnt += int'(done_m);
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL bp_done_pulses: got %0d expected 1", done_cnt);
        end
        // Back in IDLE: 8'h11 must not have been taken yet.
        checks++;
        if ({out_valid_m, in_ready_m, busy_m} !== 3'b010) begin
            failures++;
            $display("FAIL bp_idle_return: got valid/ready/busy %b expected 010",
                     {out_valid_m, in_ready_m, busy_m});
        end
        sb_m.push_back(8'h11);
        @(negedge clk);
        checks++;
        if (ser_en_m !== 1'b1) begin
            failures++;
            $display("FAIL bp_accept_after_idle: ser_en got %b expected 1", ser_en_m);
        end
        in_valid_m = 1'b0;
        collect_m(seq, en_cnt);
        exp = (sb_m.size() > 0) ? sb_m.pop_front() : 8'hxx;
        checks++;
        if (out_valid_m !== 1'b1 || out_data_m !== exp) begin
            failures++;
            $display("FAIL bp_second_word: got valid %b data %h expected 1 %h",
                     out_valid_m, out_data_m, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq;
        logic [7:0] exp;
        int         en_cnt;
        int         t1;
        int         t2;
        loop_m = 1'b1; out_ready_m = 1'b1;
        in_valid_m = 1'b1; in_data_m = 8'h3C;
        sb_m.push_back(8'h3C); sb_m.push_back(8'hC3);
        @(negedge clk);
        t1 = cyc;
        in_data_m = 8'hC3;
        collect_m(seq, en_cnt);
        exp = (sb_m.size() > 0) ? sb_m.pop_front() : 8'hxx;
        checks++;
        if (out_valid_m !== 1'b1 || out_data_m !== exp) begin
            failures++;
            $display("FAIL b2b_first_word: got valid %b data %h expected 1 %h",
                     out_valid_m, out_data_m, exp);
        end
        // Wait (bounded) for the second word to start shifting.
        t2 = -1;
        for (int i = 0; i < 20 && t2 < 0; i++) begin
            @(negedge clk);
            if (ser_en_m === 1'b1) t2 = cyc;
        end
        checks++;
        if (t2 - t1 != 10) begin
            failures++;
            $display("FAIL b2b_accept_spacing: got %0d cycles expected 10 (t2=%0d)", t2 - t1, t2);
        end
        collect_m(seq, en_cnt);
        in_valid_m = 1'b0;
        exp = (sb_m.size() > 0) ? sb_m.pop_front() : 8'hxx;
        checks++;
        if (out_valid_m !== 1'b1 || out_data_m !== exp) begin
            failures++;
            $display("FAIL b2b_second_word: got valid %b data %h expected 1 %h",
                     out_valid_m, out_data_m, exp);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_shift();
        logic [7:0] seq;
        logic [7:0] exp;
        int         en_cnt;
        int         stray;
        loop_m = 1'b1; out_ready_m = 1'b1;
        in_valid_m = 1'b1; in_data_m = 8'hF0;  // discarded, so nothing is expected
        @(negedge clk);
        in_valid_m = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ser_en_m, out_valid_m, busy_m, ser_out_m} !== 4'b0000 || out_data_m !== 8'h00) begin
            failures++;
            $display("FAIL rst_mid_shift_immediate: got en/valid/busy/out %b data %h expected 0000 00",
                     {ser_en_m, out_valid_m, busy_m, ser_out_m}, out_data_m);
        end
        stray = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stray += int'(out_valid_m) + int'(done_m);
        end
        rst_n = 1'b1;
        in_valid_m = 1'b1; in_data_m = 8'h0F; sb_m.push_back(8'h0F);
        @(negedge clk);
        in_valid_m = 1'b0;
        checks++;
        if (ser_en_m !== 1'b1) begin
            failures++;
            $display("FAIL rst_first_accept: ser_en got %b expected 1", ser_en_m);
        end
        collect_m(seq, en_cnt);
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL rst_stray_output: got %0d valid/done cycles expected 0", stray);
        end
        exp = (sb_m.size() > 0) ? sb_m.pop_front() : 8'hxx;
        checks++;
        if (out_valid_m !== 1'b1 || out_data_m !== exp) begin
            failures++;
            $display("FAIL rst_next_word: got valid %b data %h expected 1 %h",
                     out_valid_m, out_data_m, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_lsb_first();
        logic [7:0] ret_bits;
        logic [7:0] seq;
        logic [7:0] exp;
        int         en_cnt;
        ret_bits = 8'b0000_0011;  // ret_bits[i] is returned on shift edge i: 1,1,0,0,0,0,0,0
        out_ready_l = 1'b1;
        in_valid_l = 1'b1; in_data_l = 8'h01; sb_l.push_back(8'h03);
        @(negedge clk);
        in_valid_l = 1'b0;
        seq = '0;
        en_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            seq = {seq[6:0], ser_out_l};
            en_cnt += int'(ser_en_l);
            ser_in_l = ret_bits[i];
            @(negedge clk);
        end
        ser_in_l = 1'b0;
        // Sequence 1,0,0,0,0,0,0,0 packed first-bit-in-MSB.
        checks++;
        if (seq !== 8'h80 || en_cnt != 8) begin
            failures++;
            $display("FAIL lsb_ser_out_seq: got %b en %0d expected 10000000 en 8", seq, en_cnt);
        end
        exp = (sb_l.size() > 0) ? sb_l.pop_front() : 8'hxx;
        checks++;
        if (out_valid_l !== 1'b1 || done_l !== 1'b1 || out_data_l !== exp) begin
            failures++;
            $display("FAIL lsb_out_data: got valid %b done %b data %h expected 1 1 %h",
                     out_valid_l, done_l, out_data_l, exp);
        end
        @(negedge clk);
        @(negedge clk);
        // Result holds in IDLE.
        checks++;
        if (out_valid_l !== 1'b0 || out_data_l !== 8'h03) begin
            failures++;
            $display("FAIL lsb_idle_hold: got valid %b data %h expected 0 03", out_valid_l, out_data_l);
        end
    endtask

    initial begin
        test_reset();
        test_loopback_msb();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_shift();
        test_lsb_first();
        checks++;
        if (sb_m.size() != 0 || sb_l.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d/%0d words left expected 0/0", sb_m.size(), sb_l.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
